candy_div: RTL and testbench

Iterative radix-2 restoring divider for the candy CPU execute stage. It performs signed or unsigned division on a start/ready handshake and returns quotient and remainder. The ALU consumes the result through its `div_result_i`/`div_ready_i` inputs. The execute stage holds `start_i` and stalls the pipeline while the divider is busy.

---
 rtl/candy_div.sv | 156 +++++++++++++++
 tb/tb_candy_div.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/candy_div.sv
// rtl/candy_div.sv - iterative radix-2 restoring divider, signed/unsigned, start/ready handshake
// One quotient bit per clock; divide-by-zero returns quotient 0, remainder 0 after one clock.
module candy_div #(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              annul_i,
   input  logic              signed_div_i,
   input  logic [DATA_W-1:0] opdata1_i,
   input  logic [DATA_W-1:0] opdata2_i,
   output logic [DATA_W-1:0] div_result_o,
   output logic [DATA_W-1:0] div_rem_o,
   output logic              div_ready_o,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rem;
   logic [DATA_W-1:0]   r_dvd;
   logic [DATA_W-1:0]   r_dsr;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [DATA_W-1:0]   r_quot;
   logic [DATA_W-1:0]   r_remd;

   logic                w_accept;
   logic                w_last;
   logic                w_op1_neg;
   logic                w_op2_neg;
   logic [DATA_W-1:0]   w_op1_mag;
   logic [DATA_W-1:0]   w_op2_mag;
   logic [DATA_W:0]     w_shift;
   logic [DATA_W:0]     w_diff;
   logic                w_ge;
   logic [DATA_W-1:0]   w_rem_nxt;
   logic [DATA_W-1:0]   w_dvd_nxt;

   assign w_accept  = (r_state == S_FREE) && start_i && !annul_i;
   assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));

   assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
   assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
   assign w_op1_mag = w_op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
   assign w_op2_mag = w_op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

   // Partial remainder is always below the divisor, so the DATA_W+1 bit
   // difference never overflows and its MSB is a true sign bit.
   assign w_shift   = {r_rem, r_dvd[DATA_W-1]};
   assign w_diff    = w_shift - {1'b0, r_dsr};
   assign w_ge      = ~w_diff[DATA_W];
   assign w_rem_nxt = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
   assign w_dvd_nxt = {r_dvd[DATA_W-2:0], w_ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FREE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FREE: begin
            if (w_accept) begin
               w_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
         end
         S_ON: begin
            if (annul_i) begin
               w_next = S_FREE;
            end else if (w_last) begin
               w_next = S_END;
            end
         end
         S_BYZERO: begin
            w_next = annul_i ? S_FREE : S_END;
         end
         S_END: begin
            if (annul_i || !start_i) begin
               w_next = S_FREE;
            end
         end
         default: w_next = S_FREE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_quot  <= '0;
         r_remd  <= '0;
      end else begin
         case (r_state)
            S_FREE: begin
               if (w_accept) begin
                  r_cnt   <= '0;
                  r_rem   <= '0;
                  r_dvd   <= w_op1_mag;
                  r_dsr   <= w_op2_mag;
                  r_neg_q <= w_op1_neg ^ w_op2_neg;
                  r_neg_r <= w_op1_neg;
               end
            end
            S_ON: begin
               if (!annul_i) begin
                  r_cnt <= r_cnt + 1'b1;
                  r_rem <= w_rem_nxt;
                  r_dvd <= w_dvd_nxt;
                  if (w_last) begin
                     r_quot <= r_neg_q ? (~w_dvd_nxt + 1'b1) : w_dvd_nxt;
                     r_remd <= r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
                  end
               end
            end
            S_BYZERO: begin
               r_quot <= '0;
               r_remd <= '0;
            end
            S_END: begin
               if (annul_i || !start_i) begin
                  r_quot <= '0;
                  r_remd <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_result_o = r_quot;
   assign div_rem_o    = r_remd;
   assign div_ready_o  = (r_state == S_END);
   assign busy_o       = (r_state == S_ON) || (r_state == S_BYZERO);

endmodule

// File: tb/tb_candy_div.sv
// tb/tb_candy_div.sv - table, random and corner-sequence checks for candy_div
// Expected results come from plain integer division on sign-extended operands.
module tb_candy_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [23:0] opdata1_i;
   logic [23:0] opdata2_i;
   logic [23:0] div_result_o;
   logic [23:0] div_rem_o;
   logic        div_ready_o;
   logic        busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   candy_div #(.DATA_W(24)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .div_result_o (div_result_o),
      .div_rem_o    (div_rem_o),
      .div_ready_o  (div_ready_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] q;
      logic [23:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic s, input logic [23:0] a, input logic [23:0] b,
                                 output logic [23:0] q, output logic [23:0] r);
      longint sa, sb, lq, lr;
      if (b == 24'd0) begin
         q = '0;
         r = '0;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = {{40{a[23]}}, a};
         sb = {{40{b[23]}}, b};
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[23:0];
         r  = lr[23:0];
      end
   endfunction

   // Runs one full handshake from FREE and returns to FREE afterwards.
   task automatic do_div(input string name, input logic s, input logic [23:0] a,
                         input logic [23:0] b, input logic [23:0] eq,
                         input logic [23:0] er, input int elat);
      int lat;
      logic busy_ok;
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      tick();
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~s;
      lat     = 0;
      busy_ok = 1'b1;
      while (!div_ready_o && lat < 40) begin
         if (busy_o !== 1'b1) busy_ok = 1'b0;
         tick();
         lat++;
      end
      chk({name, " latency"}, lat, elat);
      chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
      chk({name, " quot"}, {8'd0, div_result_o}, {8'd0, eq});
      chk({name, " rem"}, {8'd0, div_rem_o}, {8'd0, er});
      chk({name, " busy_end"}, {31'd0, busy_o}, 32'd0);
      tick();
      chk({name, " held"}, {7'd0, div_ready_o, div_result_o}, {7'd0, 1'b1, eq});
      start_i = 1'b0;
      tick();
      chk({name, " clear"}, {7'd0, div_ready_o, div_result_o | div_rem_o}, 32'd0);
   endtask

   initial begin
      logic        s;
      logic [23:0] a, b, q, r;
      int          lat;
      logic        never_ready;

      vecs[0] = '{1'b0, 24'd100,     24'd7,       24'd14,      24'd2,       24};
      vecs[1] = '{1'b1, 24'hFFFF9C,  24'd7,       24'hFFFFF2,  24'hFFFFFE,  24};
      vecs[2] = '{1'b1, 24'd100,     24'hFFFFF9,  24'hFFFFF2,  24'd2,       24};
      vecs[3] = '{1'b1, 24'h800000,  24'hFFFFFF,  24'h800000,  24'd0,       24};
      vecs[4] = '{1'b0, 24'hFFFFFF,  24'd1,       24'hFFFFFF,  24'd0,       24};
      vecs[5] = '{1'b0, 24'd5,       24'd0,       24'd0,       24'd0,       1};
      vecs[6] = '{1'b0, 24'h800000,  24'hFFFFFF,  24'd0,       24'h800000,  24};

      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      tick();
      chk("reset outs", {6'd0, div_ready_o, busy_o, div_result_o | div_rem_o}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         do_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                vecs[i].q, vecs[i].r, vecs[i].lat);
      end

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         a = (i % 9 == 0) ? 24'h800000 : 24'($urandom);
         case ($urandom_range(0, 7))
            0:       b = 24'd0;
            1:       b = 24'hFFFFFF;
            2:       b = 24'd1;
            3, 4:    b = 24'($urandom_range(1, 300));
            default: b = 24'($urandom);
         endcase
         model(s, a, b, q, r);
         do_div($sformatf("rnd%0d", i), s, a, b, q, r, (b == 24'd0) ? 1 : 24);
      end

      // Hold divide-by-zero result for several cycles with start high.
      signed_div_i = 1'b0; opdata1_i = 24'd5; opdata2_i = 24'd0; start_i = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 4; i++) tick();
      chk("byzero hold", {6'd0, div_ready_o, busy_o, div_result_o | div_rem_o}, 32'h0200_0000);
      start_i = 1'b0;
      tick();
      chk("byzero clear", {6'd0, div_ready_o, busy_o, div_result_o}, 32'd0);

      // Annul during iteration 10.
      opdata1_i = 24'd1000; opdata2_i = 24'd3; start_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      annul_i = 1'b1; start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      chk("annul free", {30'd0, div_ready_o, busy_o}, 32'd0);
      never_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (div_ready_o !== 1'b0) never_ready = 1'b0;
         tick();
      end
      chk("annul no ready", {31'd0, never_ready}, 32'd1);
      do_div("after annul", 1'b0, 24'd50, 24'd5, 24'd10, 24'd0, 24);

      // Asynchronous reset mid-iteration.
      opdata1_i = 24'd777; opdata2_i = 24'd5; start_i = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b1;
      #1;
      chk("async rst", {6'd0, div_ready_o, busy_o, div_result_o | div_rem_o}, 32'd0);
      start_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      do_div("after rst", 1'b0, 24'd9, 24'd3, 24'd3, 24'd0, 24);

      lat = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
